// File: rtl/fact_arbiter_if.sv
// Bus bundle between the requesters/factorial unit and fact_arbiter.
// Requester side: req, n_in (in), gnt, done, rslt, err (out).
// Unit side:      fu_go, fu_n (out), fu_done, fu_rslt (in).
// The slave modport is the arbiter's view; master is the environment's view.
interface fact_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] n_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [31:0]        rslt;
    logic               err;
    logic               fu_go;
    logic [31:0]        fu_n;
    logic               fu_done;
    logic [31:0]        fu_rslt;

    modport slave (
        input  req, n_in, fu_done, fu_rslt,
        output gnt, done, rslt, err, fu_go, fu_n
    );

    modport master (
        output req, n_in, fu_done, fu_rslt,
        input  gnt, done, rslt, err, fu_go, fu_n
    );
endinterface

// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial unit among NREQ requesters.
// Latches the winner's operand, screens it against MAXN, issues it to the
// unit, waits for completion (bounded by a TIMEOUT-cycle watchdog) and
// returns the result with a one-cycle done pulse to the winner.
// Ports: clk, rst_btn (async, active-low), bus (fact_arbiter_if.slave).
// All outputs are registered.
module fact_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAXN    = 12,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_btn,
    fact_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [31:0]     rslt_q, rslt_d;
    logic            err_q, err_d;
    logic            go_q, go_d;
    logic [31:0]     fn_q, fn_d;

    logic [31:0]     ops [NREQ];
    logic            found;
    logic [IW-1:0]   win;
    logic [31:0]     win_n;
    int unsigned     cand;

    // Unpack the operand bus into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            ops[i] = bus.n_in[32*i +: 32];
        end
    end

    // Round-robin search starting at ptr, wrapping at NREQ-1
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && bus.req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
        win_n = ops[win];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rslt_d  = rslt_q;
        err_d   = err_q;
        go_d    = 1'b0;
        fn_d    = fn_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d = win;
                    gnt_d = NREQ'(1) << win;
                    if (win_n <= 32'(MAXN)) begin
                        state_d = ISSUE;
                        go_d    = 1'b1;
                        fn_d    = win_n;
                    end else begin
                        // Out-of-range operand: answer without touching the unit
                        state_d = RESP;
                        done_d  = NREQ'(1) << win;
                        rslt_d  = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wdog_d  = '0;
            end
            WAIT: begin
                // Completion takes priority over the watchdog terminal count
                if (bus.fu_done) begin
                    state_d = RESP;
                    done_d  = NREQ'(1) << idx_q;
                    rslt_d  = bus.fu_rslt;
                    err_d   = 1'b0;
                    wdog_d  = '0;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    done_d  = NREQ'(1) << idx_q;
                    rslt_d  = '0;
                    err_d   = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
                wdog_d  = '0;
                ptr_d   = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + IW'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rslt_q  <= '0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rslt_q  <= rslt_d;
            err_q   <= err_d;
            go_q    <= go_d;
            fn_q    <= fn_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rslt  = rslt_q;
    assign bus.err   = err_q;
    assign bus.fu_go = go_q;
    assign bus.fu_n  = fn_q;
endmodule

// File: tb/tb_fact_arbiter.sv
// Self-checking bench for fact_arbiter (NREQ=4, MAXN=12, TIMEOUT=16).
// A clocked factorial-unit model answers fu_go after a programmable delay.
module tb_fact_arbiter;
    logic clk;
    logic rst_btn;

    fact_arbiter_if #(.NREQ(4)) bus ();

    fact_arbiter #(.NREQ(4), .MAXN(12), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst_btn (rst_btn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Factorial unit model: fu_done lands during WAIT cycle fu_delay (0 = never)
    int          fu_delay = 0;
    int          fu_cnt   = 0;

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 2; k <= int'(n); k++) r = r * 32'(k);
        return r;
    endfunction

    always @(negedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            fu_cnt      = 0;
            bus.fu_done = 1'b0;
        end else if (bus.fu_go) begin
            fu_cnt      = fu_delay;
            bus.fu_done = 1'b0;
            bus.fu_rslt = fact(bus.fu_n);
        end else if (fu_cnt > 0) begin
            fu_cnt      = fu_cnt - 1;
            bus.fu_done = (fu_cnt == 0);
        end else begin
            bus.fu_done = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [3:0] r, input logic [31:0] op);
        for (int i = 0; i < 4; i++) bus.n_in[32*i +: 32] = r[i] ? op : 32'h0;
    endtask

    // Tick at negedges until a done pulse appears, recording what was seen
    task automatic wait_done(output logic [3:0] d, output int lat, output logic [3:0] g1,
                             output int go_cnt, output logic [31:0] fn);
        d = '0; lat = 0; g1 = '0; go_cnt = 0; fn = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) g1 = bus.gnt;
            if (bus.fu_go) begin
                go_cnt++;
                fn = bus.fu_n;
            end
            if (bus.done != 0) begin
                d = bus.done;
                return;
            end
        end
        chk("done_timeout", 32'(lat), 32'(0));
    endtask

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [31:0] op;
        int          dly;
        logic [31:0] rslt;
        logic        err;
        int          lat;
        int          go;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [3:0]  d, g1, served;
        int          lat, go_cnt;
        logic [31:0] fn;

        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0]  d, g1, served;
        int          lat, go_cnt, pulses;
        logic [31:0] fn;

        vecs[0] = '{"fact5",    4'b0001, 32'd5,          10, 32'd120,       1'b0, 12, 1};
        vecs[1] = '{"fact7",    4'b1000, 32'd7,           1, 32'd5040,      1'b0,  3, 1};
        vecs[2] = '{"fact0",    4'b0010, 32'd0,           2, 32'd1,         1'b0,  4, 1};
        vecs[3] = '{"wd_abort", 4'b0001, 32'd6,           0, 32'd0,         1'b1, 18, 1};
        vecs[4] = '{"wd_tc",    4'b0001, 32'd6,          16, 32'd720,       1'b0, 18, 1};
        vecs[5] = '{"wd_late",  4'b1000, 32'd11,         18, 32'd0,         1'b1, 18, 1};
        vecs[6] = '{"rej_max",  4'b0010, 32'hFFFF_FFFF,   0, 32'd0,         1'b1,  1, 0};
        vecs[7] = '{"rej13",    4'b0100, 32'd13,          0, 32'd0,         1'b1,  1, 0};
        vecs[8] = '{"fact12",   4'b0100, 32'd12,          3, 32'd479001600, 1'b0,  5, 1};

        rst_btn  = 1'b0;
        bus.req  = '0;
        bus.n_in = '0;
        bus.fu_rslt = '0;
        #1;
        chk("rst_gnt",  32'(bus.gnt),   32'd0);
        chk("rst_done", 32'(bus.done),  32'd0);
        chk("rst_rslt", bus.rslt,       32'd0);
        chk("rst_err",  32'(bus.err),   32'd0);
        chk("rst_go",   32'(bus.fu_go), 32'd0);
        chk("rst_fn",   bus.fu_n,       32'd0);
        repeat (2) @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);

        // Single-requester transactions
        for (int v = 0; v < 9; v++) begin
            fu_delay = vecs[v].dly;
            set_ops(vecs[v].req, vecs[v].op);
            bus.req = vecs[v].req;
            wait_done(d, lat, g1, go_cnt, fn);
            bus.req = '0;
            chk({vecs[v].name, "_done"}, 32'(d),      32'(vecs[v].req));
            chk({vecs[v].name, "_gnt"},  32'(g1),     32'(vecs[v].req));
            chk({vecs[v].name, "_rslt"}, bus.rslt,    vecs[v].rslt);
            chk({vecs[v].name, "_err"},  32'(bus.err), 32'(vecs[v].err));
            chk({vecs[v].name, "_lat"},  32'(lat),    32'(vecs[v].lat));
            chk({vecs[v].name, "_go"},   32'(go_cnt), 32'(vecs[v].go));
            if (vecs[v].go != 0) chk({vecs[v].name, "_fn"}, fn, vecs[v].op);
            pulses = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (bus.done != 0 || bus.gnt != 0 || bus.fu_go) pulses++;
            end
            chk({vecs[v].name, "_quiet"}, 32'(pulses), 32'd0);
            chk({vecs[v].name, "_hold"},  bus.rslt,    vecs[v].rslt);
        end

        // Reset during WAIT; the pointer must return to 0
        fu_delay = 10;
        set_ops(4'b1000, 32'd4);
        bus.req = 4'b1000;
        repeat (3) @(negedge clk);
        #2 rst_btn = 1'b0;
        bus.req = '0;
        #1;
        chk("mid_rst_gnt",  32'(bus.gnt),   32'd0);
        chk("mid_rst_rslt", bus.rslt,       32'd0);
        chk("mid_rst_err",  32'(bus.err),   32'd0);
        chk("mid_rst_fn",   bus.fu_n,       32'd0);
        chk("mid_rst_go",   32'(bus.fu_go), 32'd0);
        repeat (2) @(negedge clk);
        rst_btn = 1'b1;
        fu_delay = 2;
        bus.n_in = '0;
        bus.n_in[32*1 +: 32] = 32'd3;
        bus.n_in[32*3 +: 32] = 32'd2;
        bus.req = 4'b1010;
        wait_done(d, lat, g1, go_cnt, fn);
        chk("ptr_first",   32'(d), 32'b0010);
        chk("ptr_first_r", bus.rslt, 32'd6);
        bus.req = 4'b1000;
        wait_done(d, lat, g1, go_cnt, fn);
        chk("ptr_second",   32'(d), 32'b1000);
        chk("ptr_second_r", bus.rslt, 32'd2);
        bus.req = '0;
        @(negedge clk);

        // Fairness with all four requesting continuously
        for (int i = 0; i < 4; i++) bus.n_in[32*i +: 32] = 32'(i + 1);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_d;
            logic [31:0] exp_r;
            exp_d = 4'b0001 << (k % 4);
            exp_r = (k % 4 == 0) ? 32'd1 : (k % 4 == 1) ? 32'd2 : (k % 4 == 2) ? 32'd6 : 32'd24;
            wait_done(d, lat, g1, go_cnt, fn);
            chk($sformatf("fair%0d_who", k), 32'(d), 32'(exp_d));
            chk($sformatf("fair%0d_rslt", k), bus.rslt, exp_r);
            served = d;
            bus.req = bus.req & ~served;
            @(negedge clk);
            if (k < 4) bus.req = bus.req | served;
        end
        bus.req = '0;
        @(negedge clk);

        // n=0 with a second request arriving during WAIT
        fu_delay = 3;
        bus.n_in = '0;
        bus.req = 4'b0010;
        repeat (2) @(negedge clk);
        bus.n_in[32*0 +: 32] = 32'd3;
        bus.req = 4'b0011;
        wait_done(d, lat, g1, go_cnt, fn);
        chk("edge0_who",  32'(d), 32'b0010);
        chk("edge0_rslt", bus.rslt, 32'd1);
        chk("edge0_err",  32'(bus.err), 32'd0);
        bus.req = 4'b0001;
        wait_done(d, lat, g1, go_cnt, fn);
        chk("edge1_who",  32'(d), 32'b0001);
        chk("edge1_rslt", bus.rslt, 32'd6);
        bus.req = '0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done != 0) pulses++;
        end
        chk("edge_no_dup", 32'(pulses), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
